// File: rtl/ps_head_extractor_pkg.sv
// ps_head_extractor_pkg
// Shared types and helpers for the PacketStream header extractor:
//   state_t  - extractor FSM states (SOP, HEAD, HOLD, BODY)
//   hlen_w() - width of the h_len field for a given header length
package ps_head_extractor_pkg;

  typedef enum logic [1:0] {
    SOP  = 2'd0,
    HEAD = 2'd1,
    HOLD = 2'd2,
    BODY = 2'd3
  } state_t;

  // h_len must represent 0..hwords inclusive.
  function automatic int hlen_w(input int hwords);
    return $clog2(hwords + 1);
  endfunction

endpackage

// File: rtl/ps_head_extractor_if.sv
// ps_head_extractor_if
// Bundles the extractor's stream and header handshakes.
// Handshake rule (all three channels): a transfer happens on a rising clk
// edge where valid and ready are both 1; valid must not depend on ready.
//   extract                      header-extraction enable (sampled at SOP)
//   i_dat/i_val/i_eop, i_rdy     input PacketStream
//   h_dat/h_len/h_val, h_rdy     parallel header channel
//   o_dat/o_val/o_eop, o_rdy     output PacketStream
//   h_err, err_cnt               only with PS_HEAD_EXTRACTOR_ERR_EN defined
// Modports: slave = extractor side, master = environment side.
interface ps_head_extractor_if #(
  parameter int WIDTH  = 8,
  parameter int HWORDS = 4
);
  localparam int HLW = ps_head_extractor_pkg::hlen_w(HWORDS);

  logic                    extract;
  logic [WIDTH-1:0]        i_dat;
  logic                    i_val;
  logic                    i_eop;
  logic                    i_rdy;
  logic [HWORDS*WIDTH-1:0] h_dat;
  logic [HLW-1:0]          h_len;
  logic                    h_val;
  logic                    h_rdy;
  logic [WIDTH-1:0]        o_dat;
  logic                    o_val;
  logic                    o_eop;
  logic                    o_rdy;
`ifdef PS_HEAD_EXTRACTOR_ERR_EN
  logic                    h_err;
  logic [15:0]             err_cnt;
`endif

  modport slave (
    input  extract, i_dat, i_val, i_eop, h_rdy, o_rdy,
`ifdef PS_HEAD_EXTRACTOR_ERR_EN
    output h_err, err_cnt,
`endif
    output i_rdy, h_dat, h_len, h_val, o_dat, o_val, o_eop
  );

  modport master (
    output extract, i_dat, i_val, i_eop, h_rdy, o_rdy,
`ifdef PS_HEAD_EXTRACTOR_ERR_EN
    input  h_err, err_cnt,
`endif
    input  i_rdy, h_dat, h_len, h_val, o_dat, o_val, o_eop
  );

endinterface

// File: rtl/ps_head_extractor.sv
// ps_head_extractor
// Strips the first HWORDS beats of each packet (when extract=1 at SOP),
// presents them as one parallel header word, then forwards the rest of the
// packet unchanged. Packets with extract=0 pass straight through.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   bus         ps_head_extractor_if.slave (input stream, header, output stream)
//   state_o     current FSM state, for observation
// Optional macro PS_HEAD_EXTRACTOR_ERR_EN adds bus.h_err (short-header flag,
// valid with h_val) and bus.err_cnt (saturating count of short headers).
module ps_head_extractor
  import ps_head_extractor_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HWORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  ps_head_extractor_if.slave   bus,
  output state_t               state_o
);

  localparam int HLW = hlen_w(HWORDS);

  state_t           state_q;
  logic [HLW-1:0]   cnt_q;
  logic [WIDTH-1:0] slot_q [HWORDS];
  logic [HLW-1:0]   h_len_q;
  logic             h_val_q;
  logic             eop_q;      // header ended on the packet's eop

  logic                    i_rdy_c;
  logic                    o_val_c;
  logic                    accept;
  logic [HLW-1:0]          cnt_nxt;
  logic [HLW-1:0]          cap_len;
  logic                    hold_entry;
  logic [HWORDS*WIDTH-1:0] h_dat_c;

  // Ready/valid are a pure function of state and the downstream inputs;
  // h_rdy is deliberately absent so it never reaches i_rdy or o_*.
  always_comb begin
    i_rdy_c = 1'b0;
    o_val_c = 1'b0;
    unique case (state_q)
      SOP: begin
        if (bus.extract) begin
          i_rdy_c = 1'b1;
        end else begin
          i_rdy_c = bus.o_rdy;
          o_val_c = bus.i_val;
        end
      end
      HEAD: i_rdy_c = 1'b1;
      HOLD: ;
      BODY: begin
        i_rdy_c = bus.o_rdy;
        o_val_c = bus.i_val;
      end
      default: ;
    endcase
    accept  = bus.i_val & i_rdy_c;
    cnt_nxt = cnt_q + HLW'(1);
    // Header length once the current beat is captured.
    cap_len = (state_q == SOP) ? HLW'(1) : cnt_nxt;
    hold_entry = accept
               && ((state_q == SOP && bus.extract) || state_q == HEAD)
               && (bus.i_eop || cap_len == HLW'(HWORDS));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SOP;
      cnt_q   <= '0;
      h_len_q <= '0;
      h_val_q <= 1'b0;
      eop_q   <= 1'b0;
      for (int k = 0; k < HWORDS; k++) slot_q[k] <= '0;
    end else begin
      unique case (state_q)
        SOP: begin
          if (accept) begin
            if (bus.extract) begin
              // New header: older slot contents must read back as zero.
              for (int k = 0; k < HWORDS; k++)
                slot_q[k] <= (k == 0) ? bus.i_dat : '0;
              cnt_q   <= HLW'(1);
              state_q <= hold_entry ? HOLD : HEAD;
            end else if (!bus.i_eop) begin
              state_q <= BODY;
            end
          end
        end
        HEAD: begin
          if (accept) begin
            for (int k = 0; k < HWORDS; k++)
              if (cnt_q == HLW'(k)) slot_q[k] <= bus.i_dat;
            cnt_q <= cnt_nxt;
            if (hold_entry) state_q <= HOLD;
          end
        end
        HOLD: begin
          if (bus.h_rdy) begin
            h_val_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= eop_q ? SOP : BODY;
          end
        end
        BODY: begin
          if (accept && bus.i_eop) state_q <= SOP;
        end
        default: state_q <= SOP;
      endcase
      if (hold_entry) begin
        h_val_q <= 1'b1;
        h_len_q <= cap_len;
        eop_q   <= bus.i_eop;
      end
    end
  end

  always_comb begin
    h_dat_c = '0;
    for (int k = 0; k < HWORDS; k++) h_dat_c[k*WIDTH +: WIDTH] = slot_q[k];
  end

  assign bus.i_rdy = i_rdy_c;
  assign bus.o_val = o_val_c;
  assign bus.o_dat = bus.i_dat;
  assign bus.o_eop = bus.i_eop;
  assign bus.h_dat = h_dat_c;
  assign bus.h_len = h_len_q;
  assign bus.h_val = h_val_q;
  assign state_o   = state_q;

`ifdef PS_HEAD_EXTRACTOR_ERR_EN
  logic        short_hdr;
  logic        h_err_q;
  logic [15:0] err_cnt_q;

  assign short_hdr = hold_entry && bus.i_eop && (cap_len != HLW'(HWORDS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_err_q   <= 1'b0;
      err_cnt_q <= '0;
    end else if (hold_entry) begin
      h_err_q <= short_hdr;
      if (short_hdr && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign bus.h_err   = h_err_q;
  assign bus.err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_ps_head_extractor.sv
module tb_ps_head_extractor;
  import ps_head_extractor_pkg::*;

  localparam int W   = 8;
  localparam int HW  = 4;
  localparam int HLW = $clog2(HW + 1);
  localparam int HE  = 1 + HLW + HW*W;   // {short, len, hdr}

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ps_head_extractor_if #(.WIDTH(W), .HWORDS(HW)) bus();
  state_t dut_state;

  ps_head_extractor #(.WIDTH(W), .HWORDS(HW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .state_o (dut_state)
  );

  int checks = 0;
  int errors = 0;
  logic [W:0]    exp_q[$];     // {eop, dat}
  logic [HE-1:0] exp_h_q[$];   // {short, len, hdr}
  int hval_cycles = 0;
  bit bp_en = 1'b0;

  // Reference model: header = first min(len,HW) beats, rest forwarded.
  function automatic void push_expect(input logic ext, input logic [W-1:0] d[$]);
    int hl;
    logic [HW*W-1:0] hd;
    if (ext) begin
      hl = (d.size() < HW) ? d.size() : HW;
      hd = '0;
      for (int i = 0; i < hl; i++) hd[i*W +: W] = d[i];
      exp_h_q.push_back({(d.size() < HW), HLW'(hl), hd});
    end else begin
      hl = 0;
    end
    for (int i = hl; i < d.size(); i++) exp_q.push_back({(i == d.size() - 1), d[i]});
  endfunction

  // Backpressure generator.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        bus.o_rdy = 1'($urandom_range(0, 1));
        bus.h_rdy = 1'($urandom_range(0, 1));
      end
    end
  end

  // Scoreboard: every transfer on o_* and h_* is checked against the model.
  logic [W:0]    got_o, e_o;
  logic [HE-1:0] got_h, e_h, mask_h;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.h_val) hval_cycles++;
      if (bus.o_val && bus.o_rdy) begin
        got_o = {bus.o_eop, bus.o_dat};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_beat: got %h, required no beat", got_o);
        end else begin
          e_o = exp_q.pop_front();
          if (got_o !== e_o) begin
            errors++;
            $display("FAIL out_beat: got %h, required %h", got_o, e_o);
          end
        end
      end
      if (bus.h_val && bus.h_rdy) begin
`ifdef PS_HEAD_EXTRACTOR_ERR_EN
        got_h  = {bus.h_err, bus.h_len, bus.h_dat};
        mask_h = '1;
`else
        got_h  = {1'b0, bus.h_len, bus.h_dat};
        mask_h = {1'b0, {(HE-1){1'b1}}};
`endif
        checks++;
        if (exp_h_q.size() == 0) begin
          errors++;
          $display("FAIL header: got %h, required no header", got_h);
        end else begin
          e_h = exp_h_q.pop_front();
          if ((got_h & mask_h) !== (e_h & mask_h)) begin
            errors++;
            $display("FAIL header: got %h, required %h", got_h & mask_h, e_h & mask_h);
          end
        end
      end
    end
  end

  // Driver: starts and returns just after a rising edge.
  task automatic send_pkt(input logic ext, input logic [W-1:0] d[$], input bit gaps);
    bit acc;
    int n;
    push_expect(ext, d);
    bus.extract = ext;
    for (int i = 0; i < d.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.i_val = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      bus.i_val = 1'b1;
      bus.i_dat = d[i];
      bus.i_eop = (i == d.size() - 1);
      n = 0;
      acc = 1'b0;
      while (!acc && n < 200) begin
        @(negedge clk);
        acc = bus.i_rdy;
        @(posedge clk);
        #1;
        n++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: beat %0d not accepted, required acceptance", i);
        i = d.size();
      end
    end
    bus.i_val = 1'b0;
    bus.i_eop = 1'b0;
  endtask

  task automatic test_reset();
    bus.extract = 1'b0; bus.i_dat = '0; bus.i_val = 1'b0; bus.i_eop = 1'b0;
    bus.h_rdy = 1'b1; bus.o_rdy = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.h_val !== 1'b0 || bus.h_len !== '0) begin
      errors++; $display("FAIL reset_hval_hlen: got %b/%0d, required 0/0", bus.h_val, bus.h_len);
    end
    checks++;
    if (bus.h_dat !== '0) begin
      errors++; $display("FAIL reset_hdat: got %h, required 0", bus.h_dat);
    end
    checks++;
    if (bus.o_val !== 1'b0 || bus.i_rdy !== 1'b1 || dut_state !== SOP) begin
      errors++;
      $display("FAIL reset_state: got o_val=%b i_rdy=%b st=%0d, required 0 1 0",
               bus.o_val, bus.i_rdy, dut_state);
    end
`ifdef PS_HEAD_EXTRACTOR_ERR_EN
    checks++;
    if (bus.err_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_err_cnt: got %0d, required 0", bus.err_cnt);
    end
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_header_basic();
    logic [W-1:0] q[$];
    int h0, n;
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA0, 8'hA1};
    h0 = hval_cycles;
    send_pkt(1'b1, q, 1'b0);
    n = 0;
    while ((exp_q.size() != 0 || exp_h_q.size() != 0) && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0 || exp_h_q.size() != 0) begin
      errors++; $display("FAIL basic_drain: %0d items left, required 0", exp_q.size() + exp_h_q.size());
    end
    checks++;
    if (bus.h_dat !== 32'h44332211 || bus.h_len !== 3'd4) begin
      errors++; $display("FAIL basic_hdr: got %h/%0d, required 44332211/4", bus.h_dat, bus.h_len);
    end
    checks++;
    if (hval_cycles - h0 != 1) begin
      errors++; $display("FAIL basic_hval_len: got %0d cycles, required 1", hval_cycles - h0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    logic [W-1:0] q[$];
    int h0;
    q = '{8'h01, 8'h02};
    h0 = hval_cycles;
    push_expect(1'b0, q);
    bus.extract = 1'b0;
    bus.i_val = 1'b1; bus.i_dat = 8'h01; bus.i_eop = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_val !== 1'b1 || bus.o_dat !== 8'h01 || bus.o_eop !== 1'b0) begin
      errors++; $display("FAIL pass_beat0: got %b %h %b, required 1 01 0", bus.o_val, bus.o_dat, bus.o_eop);
    end
    @(posedge clk); #1;
    bus.i_dat = 8'h02; bus.i_eop = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_val !== 1'b1 || bus.o_dat !== 8'h02 || bus.o_eop !== 1'b1) begin
      errors++; $display("FAIL pass_beat1: got %b %h %b, required 1 02 1", bus.o_val, bus.o_dat, bus.o_eop);
    end
    @(posedge clk); #1;
    bus.i_val = 1'b0; bus.i_eop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (hval_cycles != h0 || exp_q.size() != 0) begin
      errors++; $display("FAIL pass_no_hdr: got %0d h_val cycles, required 0", hval_cycles - h0);
    end
  endtask

  task automatic test_short_header();
    logic [W-1:0] q[$];
    int n;
`ifdef PS_HEAD_EXTRACTOR_ERR_EN
    logic [15:0] c0;
    c0 = bus.err_cnt;
`endif
    q = '{8'h55, 8'h66};
    send_pkt(1'b1, q, 1'b0);
    n = 0;
    while (exp_h_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (exp_h_q.size() != 0) begin
      errors++; $display("FAIL short_drain: header not delivered, required delivery");
    end
`ifdef PS_HEAD_EXTRACTOR_ERR_EN
    checks++;
    if (bus.h_err !== 1'b1 || bus.err_cnt !== c0 + 16'd1) begin
      errors++; $display("FAIL short_err: got %b/%0d, required 1/%0d", bus.h_err, bus.err_cnt, c0 + 16'd1);
    end
`endif
    @(posedge clk); #1;
    checks++;
    if (bus.h_dat !== 32'h00006655 || bus.h_len !== 3'd2) begin
      errors++; $display("FAIL short_hdr: got %h/%0d, required 00006655/2", bus.h_dat, bus.h_len);
    end
  endtask

  task automatic test_hold_stall();
    logic [W-1:0] q[$];
    logic [HW*W-1:0] held;
    int n;
    for (int i = 0; i < 6; i++) q.push_back(W'($urandom_range(0, 255)));
    bus.h_rdy = 1'b0;
    fork
      send_pkt(1'b1, q, 1'b0);
      begin
        n = 0;
        while (!bus.h_val && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!bus.h_val) begin
          errors++; $display("FAIL stall_hval: got 0, required 1");
        end
        held = bus.h_dat;
        for (int c = 0; c < 5; c++) begin
          checks++;
          if (bus.i_rdy !== 1'b0 || bus.o_val !== 1'b0 || bus.h_dat !== held) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d got i_rdy=%b o_val=%b h_dat=%h, required 0 0 %h",
                     c, bus.i_rdy, bus.o_val, bus.h_dat, held);
          end
          @(negedge clk);
        end
        @(posedge clk); #1;
        bus.h_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.h_val !== 1'b1 || bus.o_val !== 1'b0) begin
          errors++; $display("FAIL stall_release: got h_val=%b o_val=%b, required 1 0", bus.h_val, bus.o_val);
        end
        @(negedge clk);
        checks++;
        if (bus.o_val !== 1'b1 || bus.o_dat !== q[4]) begin
          errors++; $display("FAIL stall_payload: got %b %h, required 1 %h", bus.o_val, bus.o_dat, q[4]);
        end
      end
    join
    n = 0;
    while ((exp_q.size() != 0 || exp_h_q.size() != 0) && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0 || exp_h_q.size() != 0) begin
      errors++; $display("FAIL stall_drain: %0d items left, required 0", exp_q.size() + exp_h_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q[$];
    int n;
    bp_en = 1'b1;
    for (int p = 0; p < 100; p++) begin
      q.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) q.push_back(W'($urandom_range(0, 255)));
      send_pkt(1'($urandom_range(0, 1)), q, 1'($urandom_range(0, 1)));
    end
    n = 0;
    while ((exp_q.size() != 0 || exp_h_q.size() != 0) && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0 || exp_h_q.size() != 0) begin
      errors++; $display("FAIL random_drain: %0d items left, required 0", exp_q.size() + exp_h_q.size());
    end
    bp_en = 1'b0;
    @(posedge clk); #1;
    bus.o_rdy = 1'b1; bus.h_rdy = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_packet();
    logic [W-1:0] q[$];
    logic [HW*W-1:0] hd;
    int n;
    bus.extract = 1'b1;
    bus.i_val = 1'b1; bus.i_dat = 8'hAA; bus.i_eop = 1'b0;
    @(posedge clk); #1;
    bus.i_dat = 8'hBB;
    @(posedge clk); #1;
    bus.i_val = 1'b0;
    reset = 1'b1;
    #2;
    checks++;
    if (bus.h_val !== 1'b0 || bus.h_len !== '0 || bus.h_dat !== '0 || dut_state !== SOP) begin
      errors++;
      $display("FAIL midreset_clear: got h_val=%b h_len=%0d h_dat=%h st=%0d, required 0 0 0 0",
               bus.h_val, bus.h_len, bus.h_dat, dut_state);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    hd = '0;
    for (int i = 0; i < 6; i++) q.push_back(W'($urandom_range(0, 255)));
    for (int i = 0; i < HW; i++) hd[i*W +: W] = q[i];
    send_pkt(1'b1, q, 1'b0);
    n = 0;
    while ((exp_q.size() != 0 || exp_h_q.size() != 0) && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (bus.h_dat !== hd || bus.h_len !== 3'd4 || exp_h_q.size() != 0) begin
      errors++; $display("FAIL midreset_hdr: got %h/%0d, required %h/4", bus.h_dat, bus.h_len, hd);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_header_basic();
    test_passthrough();
    test_short_header();
    test_hold_stall();
    test_back_to_back();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
